// File: rtl/psubsb_seq_pkg.sv
// Shared constants and types for the nibble-parallel saturating subtractor.
// Lane geometry, FSM encoding and saturation limits live here.
package psubsb_seq_pkg;

    localparam int NIB_W   = 4;
    localparam int NUM_NIB = 4;
    localparam int DATA_W  = NIB_W * NUM_NIB;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] SAT_POS = 4'h7;
    localparam logic [3:0] SAT_NEG = 4'h8;

endpackage

// File: rtl/psubsb_seq_nibble_sub_sat.sv
// One signed 4-bit lane: a - b clamped to [-8, +7].
// Shared by all lanes of psubsb_seq, one lane per cycle.
module nibble_sub_sat
    import psubsb_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] res,
    output logic       ovfl
);

    logic [3:0] raw;

    // Two's complement subtract, then clamp toward the sign of a
    always_comb begin
        raw  = a + ~b + 4'd1;
        ovfl = (a[3] != b[3]) && (raw[3] != a[3]);
        res  = raw;
        if (ovfl) begin
            res = a[3] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/psubsb_seq.sv
// Iterative nibble-parallel saturating subtractor, one lane per cycle.
// Operands are captured on start; results hold until the next launch.
module psubsb_seq
    import psubsb_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Diff,
    output logic [3:0]  ovfl
);

    state_t      state;
    state_t      next_state;
    logic [1:0]  cnt;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] diff_q;
    logic [3:0]  ovfl_q;
    logic        load;
    logic [3:0]  lane_we;
    logic [3:0]  lane_a;
    logic [3:0]  lane_b;
    logic [3:0]  lane_r;
    logic        lane_ov;

    // Next-state and handshake outputs; a launch is accepted in IDLE or DONE
    always_comb begin
        next_state = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 2'd3) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register and lane counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= next_state;
            if (load) begin
                cnt <= 2'd0;
            end else if (state == RUN) begin
                cnt <= cnt + 2'd1;
            end
        end
    end

    // Operand capture so input changes during RUN are invisible
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= 16'h0000;
            b_q <= 16'h0000;
        end else if (load) begin
            a_q <= A;
            b_q <= B;
        end
    end

    // Lane select into the shared datapath
    always_comb begin
        lane_a = a_q[{cnt, 2'b00} +: NIB_W];
        lane_b = b_q[{cnt, 2'b00} +: NIB_W];
    end

    // Write-enable decode: only the current lane updates in RUN
    always_comb begin
        lane_we = 4'b0000;
        if (state == RUN) begin
            lane_we[cnt] = 1'b1;
        end
    end

    nibble_sub_sat u_lane (
        .a    (lane_a),
        .b    (lane_b),
        .res  (lane_r),
        .ovfl (lane_ov)
    );

    // Result registers: cleared on launch, filled lane by lane
    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= 16'h0000;
            ovfl_q <= 4'h0;
        end else if (load) begin
            diff_q <= 16'h0000;
            ovfl_q <= 4'h0;
        end else begin
            for (int i = 0; i < NUM_NIB; i++) begin
                if (lane_we[i]) begin
                    diff_q[i*NIB_W +: NIB_W] <= lane_r;
                    ovfl_q[i]                <= lane_ov;
                end
            end
        end
    end

    assign Diff = diff_q;
    assign ovfl = ovfl_q;

endmodule

// File: tb/tb_psubsb_seq.sv
// Scoreboard bench for psubsb_seq: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_psubsb_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic [3:0]  ovfl;

    logic [19:0] sb[$];
    int          errors;
    int          checks;
    int          done_seen;
    int          lat;
    int          bc;
    int          d0;

    psubsb_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Diff  (Diff),
        .ovfl  (ovfl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && done) begin
            logic [19:0] exp_v;
            done_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got Diff=%h ovfl=%b, no result expected",
                         Diff, ovfl);
            end else begin
                exp_v = sb.pop_front();
                if ({Diff, ovfl} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got Diff=%h ovfl=%b, expected Diff=%h ovfl=%b",
                             Diff, ovfl, exp_v[19:4], exp_v[3:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for its done cycle.
    // glitch >= 0 pulses start with altered A at that RUN sample.
    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ed, input logic [3:0] eo,
                      input int glitch, output int lt, output int bcnt);
        start = 1'b1;
        A     = a;
        B     = b;
        sb.push_back({ed, eo});
        step();
        start = 1'b0;
        lt    = 0;
        bcnt  = 0;
        while (!done && lt < 20) begin
            if (busy) bcnt++;
            if (lt == glitch) begin
                start = 1'b1;
                A     = ~a;
            end else begin
                start = 1'b0;
            end
            step();
            lt++;
        end
        start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected 4", lt);
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        done_seen = 0;
        rst   = 1'b1;
        start = 1'b0;
        A     = 16'h0;
        B     = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_diff", 32'(Diff), 32'h0);
        check("reset_ovfl", 32'(ovfl), 32'h0);
        rst = 1'b0;
        step();

        // basic subtract, latency and busy width
        op(16'h1234, 16'h1111, 16'h0123, 4'h0, -1, lat, bc);
        check("t1_latency", 32'(lat), 32'd4);
        check("t1_busy_cycles", 32'(bc), 32'd4);
        step();
        check("t1_idle_busy", 32'(busy), 32'd0);
        check("t1_hold_diff", 32'(Diff), 32'h0123);

        // positive and negative saturation in the top lane
        op(16'h7000, 16'h8000, 16'h7000, 4'b1000, -1, lat, bc);
        step();
        op(16'h8000, 16'h1000, 16'h8000, 4'b1000, -1, lat, bc);
        step();

        // boundary lanes and mixed patterns
        op(16'h0000, 16'h0888, 16'h0777, 4'b0111, -1, lat, bc);
        step();
        op(16'h8888, 16'h8888, 16'h0000, 4'h0, -1, lat, bc);
        step();
        op(16'h5F3A, 16'h2A79, 16'h35C1, 4'h0, -1, lat, bc);
        step();
        op(16'h0009, 16'h0003, 16'h0008, 4'b0001, -1, lat, bc);
        step();

        // start and new A during RUN are ignored
        d0 = done_seen;
        op(16'h1234, 16'h1111, 16'h0123, 4'h0, 2, lat, bc);
        check("t4_latency", 32'(lat), 32'd4);
        repeat (6) step();
        check("t4_done_count", 32'(done_seen - d0), 32'd1);

        // back-to-back launch from DONE
        op(16'h7000, 16'h8000, 16'h7000, 4'b1000, -1, lat, bc);
        op(16'h0000, 16'h0888, 16'h0777, 4'b0111, -1, lat, bc);
        check("t5_done_gap", 32'(lat + 1), 32'd5);
        check("t5_no_idle", 32'(bc), 32'd4);
        step();

        // reset in the third RUN cycle aborts the operation
        start = 1'b1;
        A     = 16'h1234;
        B     = 16'h5555;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_diff", 32'(Diff), 32'h0);
        check("t6_ovfl", 32'(ovfl), 32'h0);
        d0 = done_seen;
        repeat (6) step();
        check("t6_no_done", 32'(done_seen - d0), 32'd0);
        op(16'h1234, 16'h1111, 16'h0123, 4'h0, -1, lat, bc);
        check("t6_latency", 32'(lat), 32'd4);
        step();
        step();

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
